huffman_frame_ctrl: RTL

//  Frame sequencer for the 6-symbol huffman core. On start, resets the core, wins the shared image-memory bus,

---
 rtl/huffman_pkg.sv | 34 +++
 rtl/hfc_timeout_timer.sv | 31 +++
 rtl/huffman_frame_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared types for the huffman frame sequencer: FSM states, error codes and
// the packed {S6,...,S1} symbol-vector layout used by the core interface.
package huffman_pkg;

  localparam int NSYM  = 6;
  localparam int SYM_W = 8;
  localparam int VEC_W = NSYM * SYM_W;

  typedef logic [VEC_W-1:0] sym_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRST   = 3'd1,
    ST_REQ    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_W_CNT  = 3'd5,
    ST_W_CODE = 3'd6,
    ST_FIN    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_BADLEN   = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_GNT_LOST = 2'd3
  } err_e;

  // Symbol numbers are 1-based; symbol 1 sits in the least significant byte.
  function automatic logic [SYM_W-1:0] sym_field(input sym_vec_t v, input int unsigned sym);
    return v[(sym-1)*SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/hfc_timeout_timer.sv
// Saturating wait timer; expire is asserted while the count equals TIMEOUT-1,
// so a wait that starts with a clear times out after exactly TIMEOUT cycles.
module hfc_timeout_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;

  // Count enabled cycles, clear wins, hold at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {TW{1'b0}};
    end else if (clear) begin
      count_q <= {TW{1'b0}};
    end else if (enable && (count_q != {TW{1'b1}})) begin
      count_q <= count_q + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer for the 6-symbol huffman core: resets the core, streams one
// frame from image memory as an unbroken burst and latches the core results.
module huffman_frame_ctrl
  import huffman_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 255,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [7:0]        frame_len,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              mem_req,
  output logic              mem_lock,
  input  logic              mem_gnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              core_rst,
  output logic              gray_valid,
  output logic [7:0]        gray_data,
  input  logic [VEC_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic [VEC_W-1:0]  hc_in,
  input  logic [VEC_W-1:0]  m_in,
  input  logic              code_valid,
  output logic [VEC_W-1:0]  res_cnt,
  output logic [VEC_W-1:0]  res_hc,
  output logic [VEC_W-1:0]  res_m,
  output logic              res_valid,
  output logic [15:0]       frame_cnt
);

  state_e            state_q;
  err_e              err_q;
  logic [ADDR_W-1:0] base_q, mem_addr_q;
  logic [7:0]        len_q, rd_cnt_q, gray_data_q;
  logic              crst_cnt_q, rd_pend_q;
  logic              busy_q, done_q, mem_req_q, mem_lock_q, mem_rd_en_q;
  logic              core_rst_q, gray_valid_q, res_valid_q;
  logic [VEC_W-1:0]  res_cnt_q, res_hc_q, res_m_q;
  logic [15:0]       frame_cnt_q;

  logic tmr_clear_s, tmr_en_s, tmr_expire_s, bad_len_s;

  assign bad_len_s   = (frame_len == 8'd0) || ({1'b0, frame_len} > 9'(MAX_LEN));
  // DRAIN precedes W_CNT and a cnt_valid hand-off precedes W_CODE: both waits start at zero.
  assign tmr_clear_s = (state_q == ST_DRAIN) || ((state_q == ST_W_CNT) && cnt_valid);
  assign tmr_en_s    = (state_q == ST_W_CNT) || (state_q == ST_W_CODE);

  hfc_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear_s),
    .enable (tmr_en_s),
    .expire (tmr_expire_s)
  );

  // Frame sequencer with registered bus, core and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      err_q        <= ERR_OK;
      base_q       <= {ADDR_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      len_q        <= 8'd0;
      rd_cnt_q     <= 8'd0;
      gray_data_q  <= 8'd0;
      crst_cnt_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_lock_q   <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      core_rst_q   <= 1'b0;
      gray_valid_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_cnt_q    <= {VEC_W{1'b0}};
      res_hc_q     <= {VEC_W{1'b0}};
      res_m_q      <= {VEC_W{1'b0}};
      frame_cnt_q  <= 16'd0;
    end else begin
      done_q       <= 1'b0;
      rd_pend_q    <= mem_rd_en_q;
      gray_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        gray_data_q <= mem_rdata;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q      <= frame_base;
            len_q       <= frame_len;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bad_len_s) begin
              err_q   <= ERR_BADLEN;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              err_q      <= ERR_OK;
              core_rst_q <= 1'b1;
              crst_cnt_q <= 1'b0;
              state_q    <= ST_CRST;
            end
          end
        end
        ST_CRST: begin
          if (crst_cnt_q) begin
            core_rst_q <= 1'b0;
            mem_req_q  <= 1'b1;
            state_q    <= ST_REQ;
          end else begin
            crst_cnt_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_lock_q  <= 1'b1;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= base_q;
            rd_cnt_q    <= 8'd1;
            state_q     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (mem_lock_q && !mem_gnt) begin
            // Lost the bus: squash the in-flight read so the core sees no partial pixel.
            mem_req_q    <= 1'b0;
            mem_lock_q   <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            gray_valid_q <= 1'b0;
            err_q        <= ERR_GNT_LOST;
            done_q       <= 1'b1;
            state_q      <= ST_FIN;
          end else if (rd_cnt_q == len_q) begin
            mem_req_q   <= 1'b0;
            mem_lock_q  <= 1'b0;
            mem_rd_en_q <= 1'b0;
            state_q     <= ST_DRAIN;
          end else begin
            mem_addr_q <= mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            rd_cnt_q   <= rd_cnt_q + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (!rd_pend_q) begin
            state_q <= ST_W_CNT;
          end
        end
        ST_W_CNT: begin
          if (cnt_valid) begin
            res_cnt_q <= cnt_in;
            if (code_valid) begin
              res_hc_q    <= hc_in;
              res_m_q     <= m_in;
              res_valid_q <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              done_q      <= 1'b1;
              state_q     <= ST_FIN;
            end else begin
              state_q <= ST_W_CODE;
            end
          end else if (tmr_expire_s) begin
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_W_CODE: begin
          if (code_valid) begin
            res_hc_q    <= hc_in;
            res_m_q     <= m_in;
            res_valid_q <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            done_q      <= 1'b1;
            state_q     <= ST_FIN;
          end else if (tmr_expire_s) begin
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The core must see reset for as long as the controller itself is in reset.
  assign core_rst   = core_rst_q | reset;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_req    = mem_req_q;
  assign mem_lock   = mem_lock_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign gray_valid = gray_valid_q;
  assign gray_data  = gray_data_q;
  assign res_cnt    = res_cnt_q;
  assign res_hc     = res_hc_q;
  assign res_m      = res_m_q;
  assign res_valid  = res_valid_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
